// File: rtl/clock_meter_pkg.sv
// Shared types and defaults for the clock period meter and its clockdiv users.
package clock_meter_pkg;

    localparam int unsigned DEFAULT_CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        STALLED
    } meter_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input, plus single-cycle rise/fall strobes.
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic iclk,
    input  logic irst_n,
    input  logic iasync,
    output logic osync,
    output logic orise,
    output logic ofall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_dly_q;

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            sync_q     <= '0;
            sync_dly_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], iasync};
            sync_dly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        osync = sync_q[SYNC_STAGES-1];
        orise = sync_q[SYNC_STAGES-1] & ~sync_dly_q;
        ofall = ~sync_q[SYNC_STAGES-1] & sync_dly_q;
    end

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of an asynchronous square wave in iclk cycles,
// with a one-cycle valid strobe per period and a stall flag when edges stop.
module clock_period_meter
    import clock_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = DEFAULT_CNT_W,
    parameter int unsigned TIMEOUT     = 50_000_000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             iclk,
    input  logic             irst_n,
    input  logic             isig,
    input  logic             iclr,
    output logic [CNT_W-1:0] operiod,
    output logic [CNT_W-1:0] ohigh,
    output logic             ovalid,
    output logic             ostall
);

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    meter_state_t state_q, state_d;

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             stall_q, stall_d;

    logic rise;
    logic fall;
    logic sync_unused;
    logic at_timeout;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .iclk  (iclk),
        .irst_n(irst_n),
        .iasync(isig),
        .osync (sync_unused),
        .orise (rise),
        .ofall (fall)
    );

    assign at_timeout = (count_q == TIMEOUT_VAL);

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A rise wins over a timeout landing on the same cycle.
    always_comb begin
        state_d = state_q;
        if (iclr) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rise) state_d = MEASURE;
                end
                MEASURE: begin
                    if (!rise && at_timeout) state_d = STALLED;
                end
                STALLED: begin
                    if (rise) state_d = MEASURE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        count_d  = count_q;
        hi_lat_d = hi_lat_q;
        period_d = period_q;
        high_d   = high_q;
        valid_d  = 1'b0;
        stall_d  = stall_q;
        if (iclr) begin
            count_d  = '0;
            hi_lat_d = '0;
            period_d = '0;
            high_d   = '0;
            stall_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // First edge only arms the measurement.
                    if (rise) count_d = CNT_ONE;
                end
                MEASURE: begin
                    if (rise) begin
                        period_d = count_q;
                        high_d   = hi_lat_q;
                        valid_d  = 1'b1;
                        count_d  = CNT_ONE;
                    end else begin
                        if (fall) hi_lat_d = count_q;
                        if (at_timeout) begin
                            stall_d  = 1'b1;
                            period_d = '0;
                            high_d   = '0;
                        end else begin
                            count_d = count_q + CNT_ONE;
                        end
                    end
                end
                STALLED: begin
                    if (rise) begin
                        stall_d = 1'b0;
                        count_d = CNT_ONE;
                    end
                end
                default: begin
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            count_q  <= '0;
            hi_lat_q <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            count_q  <= count_d;
            hi_lat_q <= hi_lat_d;
            period_q <= period_d;
            high_q   <= high_d;
            valid_q  <= valid_d;
            stall_q  <= stall_d;
        end
    end

    always_comb begin
        operiod = period_q;
        ohigh   = high_q;
        ovalid  = valid_q;
        ostall  = stall_q;
    end

endmodule
